seg7_scan_driver: RTL and testbench

- Reads the four BCD stopwatch digits (min_l, min_r, sec_l, sec_r) and drives a 4-digit common-anode 7-segment display by time-multiplexing.
- Each digit gets a fixed scan slot, with a dead-time at the start of every slot to suppress ghosting.
- Supports per-digit blinking for pause/adjust indication and optional leading-zero suppression on min_l.
- Sits between the counter and the board's an/seg/dp pins.

---
 rtl/seg7_scan_driver.sv | 116 +++++++++++
 tb/tb_seg7_scan_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Slot dead-time, per-digit blinking and min_l leading-zero blanking.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int BLINK_SLOTS  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] min_l,
  input  logic [4:0] min_r,
  input  logic [4:0] sec_l,
  input  logic [4:0] sec_r,
  input  logic       blink_en,
  input  logic [3:0] blink_mask,
  input  logic       lz_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_SLOTS - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [4:0]    hold;
  logic [BW-1:0] bcnt;
  logic          phase;

  logic       slot_end;
  logic       blink_end;
  logic [4:0] sel;
  logic [6:0] pat;
  logic       sup;
  logic       lit;
  logic [3:0] an_nxt;
  logic       dp_nxt;

  assign slot_end  = (cnt == CNT_LAST);
  assign blink_end = (bcnt == BCNT_LAST);

  always_comb begin
    sel = sec_r;
    case (idx)
      2'd0: sel = sec_r;
      2'd1: sel = sec_l;
      2'd2: sel = min_r;
      2'd3: sel = min_l;
      default: sel = sec_r;
    endcase
  end

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
  always_comb begin
    pat = 7'b0111111;
    case (hold)
      5'd0: pat = 7'b1000000;
      5'd1: pat = 7'b1111001;
      5'd2: pat = 7'b0100100;
      5'd3: pat = 7'b0110000;
      5'd4: pat = 7'b0011001;
      5'd5: pat = 7'b0010010;
      5'd6: pat = 7'b0000010;
      5'd7: pat = 7'b1111000;
      5'd8: pat = 7'b0000000;
      5'd9: pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
  end

  always_comb begin
    sup = (blink_en && phase && blink_mask[idx])
       || (lz_en && (idx == 2'd3) && (hold == 5'd0));
    lit = (cnt >= CNT_BLANK) && !sup;
    an_nxt = lit ? ~(4'b0001 << idx) : 4'b1111;
    dp_nxt = !(lit && (idx == 2'd2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= 2'd0;
      hold  <= 5'd0;
      bcnt  <= '0;
      phase <= 1'b0;
      an    <= 4'b1111;
      seg   <= 7'b1111111;
      dp    <= 1'b1;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
        if (blink_end) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
      // Capture once per slot so a digit never tears mid-slot.
      if (cnt == '0)
        hold <= sel;
      an  <= an_nxt;
      seg <= pat;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: elapsed-cycle reference model plus
// directed checks of scan order, capture, dash, blanking and blink.
module tb_seg7_scan_driver;

  localparam int R  = 8;
  localparam int BL = 2;
  localparam int BS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] min_l, min_r, sec_l, sec_r;
  logic       blink_en;
  logic [3:0] blink_mask;
  logic       lz_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int vecs = 0;
  int errs = 0;

  seg7_scan_driver #(
    .REFRESH_DIV(R), .BLANK_CYCLES(BL), .BLINK_SLOTS(BS)
  ) dut (
    .clk(clk), .rst(rst),
    .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .blink_en(blink_en), .blink_mask(blink_mask), .lz_en(lz_en),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int v);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (v >= 0 && v <= 9) return tbl[v];
    return 7'h3f;
  endfunction

  // Reference: everything follows from edges elapsed since reset.
  int         k = 0;
  bit         mvalid = 0;
  int         cap = 0;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  bit         e_chkseg;

  always @(posedge clk) begin
    int c, s, d, ph;
    bit dark;
    if (rst) begin
      k = 0;
      mvalid = 1;
      e_an = 4'hf; e_seg = 7'h7f; e_dp = 1'b1; e_chkseg = 1;
    end else if (mvalid) begin
      c  = k % R;
      s  = k / R;
      d  = s % 4;
      ph = (s / BS) % 2;
      if (c == 0)
        cap = (d == 0) ? int'(sec_r) : (d == 1) ? int'(sec_l)
            : (d == 2) ? int'(min_r) : int'(min_l);
      dark = (blink_en && ph == 1 && blink_mask[d])
          || (lz_en && d == 3 && cap == 0);
      if (c >= BL && !dark) begin
        e_an = 4'hf;
        e_an[d] = 1'b0;
        e_chkseg = 1;
      end else begin
        e_an = 4'hf;
        e_chkseg = 0;
      end
      e_seg = glyph(cap);
      e_dp  = !(e_an != 4'hf && d == 2);
      k++;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      vecs++;
      if (an !== e_an) begin
        errs++;
        $display("FAIL model_an k=%0d got %b want %b", k, an, e_an);
      end
      vecs++;
      if (dp !== e_dp) begin
        errs++;
        $display("FAIL model_dp k=%0d got %b want %b", k, dp, e_dp);
      end
      if (e_chkseg) begin
        vecs++;
        if (seg !== e_seg) begin
          errs++;
          $display("FAIL model_seg k=%0d got %b want %b", k, seg, e_seg);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] a_an,
                     input logic [6:0] a_seg, input logic a_dp,
                     input logic [3:0] w_an, input logic [6:0] w_seg,
                     input logic w_dp, input bit use_seg);
    vecs++;
    if (a_an !== w_an || a_dp !== w_dp || (use_seg && a_seg !== w_seg)) begin
      errs++;
      $display("FAIL %s got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
               nm, a_an, a_seg, a_dp, w_an, w_seg, w_dp);
    end
  endtask

  initial begin
    rst = 1'b1;
    min_l = 5'd1; min_r = 5'd2; sec_l = 5'd3; sec_r = 5'd4;
    blink_en = 1'b0; blink_mask = 4'b0000; lz_en = 1'b0;
    tick(3);
    chk("reset", an, seg, dp, 4'b1111, 7'b1111111, 1'b1, 1);
    rst = 1'b0;
    tick(2);
    chk("dead_time", an, seg, dp, 4'b1111, 7'b0, 1'b1, 0);
    tick(1);
    chk("slot0_first", an, seg, dp, 4'b1110, 7'b0011001, 1'b1, 1);
    tick(6);
    chk("slot1_dead", an, seg, dp, 4'b1111, 7'b0, 1'b1, 0);
    tick(2);
    chk("slot1_d3", an, seg, dp, 4'b1101, 7'b0110000, 1'b1, 1);
    tick(8);
    chk("slot2_d2_dp", an, seg, dp, 4'b1011, 7'b0100100, 1'b0, 1);
    tick(8);
    chk("slot3_d1", an, seg, dp, 4'b0111, 7'b1111001, 1'b1, 1);
    tick(9);
    sec_r = 5'd7;
    tick(2);
    chk("no_tear", an, seg, dp, 4'b1110, 7'b0011001, 1'b1, 1);
    tick(29);
    chk("new_capture", an, seg, dp, 4'b1110, 7'b1111000, 1'b1, 1);
    tick(1);
    sec_l = 5'd12;
    tick(7);
    chk("dash", an, seg, dp, 4'b1101, 7'b0111111, 1'b1, 1);
    min_l = 5'd0;
    lz_en = 1'b1;
    tick(18);
    chk("lz_dark", an, seg, dp, 4'b1111, 7'b0, 1'b1, 0);
    tick(3);
    lz_en = 1'b0;
    tick(27);
    chk("lz_off_zero", an, seg, dp, 4'b0111, 7'b1000000, 1'b1, 1);
    tick(5);
    blink_en = 1'b1;
    blink_mask = 4'b0011;
    tick(35);
    chk("blink_d0_dark", an, seg, dp, 4'b1111, 7'b0, 1'b1, 0);
    tick(8);
    chk("blink_d1_dark", an, seg, dp, 4'b1111, 7'b0, 1'b1, 0);
    tick(8);
    chk("blink_d2_on", an, seg, dp, 4'b1011, 7'b0100100, 1'b0, 1);
    tick(16);
    chk("blink_d0_back", an, seg, dp, 4'b1110, 7'b1111000, 1'b1, 1);
    tick(48);
    chk("pre_reset_d2", an, seg, dp, 4'b1011, 7'b0100100, 1'b0, 1);
    rst = 1'b1;
    tick(1);
    chk("mid_reset", an, seg, dp, 4'b1111, 7'b1111111, 1'b1, 1);
    rst = 1'b0;
    tick(3);
    chk("restart_phase0", an, seg, dp, 4'b1110, 7'b1111000, 1'b1, 1);
    tick(40);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
